laser_shot: RTL

//  Player laser controller, directly downstream of the spaceship stage: consumes gunPosition.

---
 rtl/space_invaders_pkg.sv | 36 +++
 rtl/rise_detect.sv | 23 ++
 rtl/laser_shot.sv | 134 +++++++++++++
 3 files changed

// File: rtl/space_invaders_pkg.sv
// Shared definitions for the space-invaders display pipeline.
// Contents: display colour codes used by the priority mux, screen and ship
// geometry, laser geometry/timing constants and the laser FSM state encoding.
package space_invaders_pkg;

    typedef enum logic [2:0] {
        COL_BACKGROUND = 3'd0,
        COL_SPACESHIP  = 3'd1,
        COL_ALIENS0    = 3'd2,
        COL_ALIENS1    = 3'd3,
        COL_ALIENS2    = 3'd4,
        COL_ALIENS3    = 3'd5,
        COL_LASER      = 3'd6,
        COL_NONE       = 3'd7
    } color_t;

    localparam int SCREEN_WIDTH  = 640;
    localparam int SCREEN_HEIGHT = 480;
    localparam int SHIP_WIDTH    = 32;
    localparam int SHIP_HEIGHT   = 30;
    localparam int V_OFFSET      = 10;
    localparam int H_OFFSET      = 10;

    localparam int LASER_WIDTH   = 4;
    localparam int LASER_HEIGHT  = 12;
    localparam int LASER_STEP    = 8;
    localparam int COOLDOWN      = 30;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FLYING = 2'd1,
        ST_END    = 2'd2,
        ST_COOL   = 2'd3
    } laser_state_t;

endpackage

// File: rtl/rise_detect.sv
// Registered rising-edge detector.
// Ports: clk, rst_n (async active-low), d (level input), rise (high for the
// first cycle d is seen high after being low).
module rise_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic rise
);

    logic d_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d_q <= 1'b0;
        end else begin
            d_q <= d;
        end
    end

    assign rise = d & ~d_q;

endmodule

// File: rtl/laser_shot.sv
// Player laser controller: launches one laser from the ship nose on a fire
// press, moves it down by LASER_STEP each frameTick, kills it on a hit or when
// it would leave the screen, and produces the per-pixel laser colour code.
// Ports: clk, reset (async active-low), fire (level), frameTick, hit,
// gunPosition (ship centre x), hPos/vPos (current pixel), laserActive,
// laserX (centre x), laserY (top y), color (registered, 1-clk latency).
// Optional build macro: LASER_COOLDOWN_EN adds a COOL state that blocks
// refiring for COOLDOWN frames after a shot ends.
//
// state  | meaning
// IDLE   | no laser, waiting for a fire press
// FLYING | laser in flight, moves on frameTick
// END    | one-cycle gap after the laser dies
// COOL   | counting frames before refire (LASER_COOLDOWN_EN only)
module laser_shot
    import space_invaders_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       fire,
    input  logic       frameTick,
    input  logic       hit,
    input  logic [9:0] gunPosition,
    input  logic [9:0] hPos,
    input  logic [9:0] vPos,
    output logic       laserActive,
    output logic [9:0] laserX,
    output logic [9:0] laserY,
    output logic [2:0] color
);

    localparam logic [9:0]  LAUNCH_Y   = 10'(V_OFFSET + SHIP_HEIGHT);
    localparam logic [9:0]  STEP10     = 10'(LASER_STEP);
    localparam logic [10:0] STEP11     = 11'(LASER_STEP);
    localparam logic [10:0] HEIGHT11   = 11'(LASER_HEIGHT);
    localparam logic [10:0] HALF_W11   = 11'(LASER_WIDTH / 2);
    localparam logic [10:0] BOTTOM11   = 11'(SCREEN_HEIGHT - V_OFFSET);

    laser_state_t state;
    logic         fire_edge;
    logic [10:0]  h_ext, v_ext, x_ext, y_ext;
    logic         exits_screen;
    logic         on_laser;

`ifdef LASER_COOLDOWN_EN
    localparam int COOL_W = $clog2(COOLDOWN + 1);
    logic [COOL_W-1:0] cool_cnt;
`endif

    rise_detect u_fire_edge (
        .clk   (clk),
        .rst_n (reset),
        .d     (fire),
        .rise  (fire_edge)
    );

    // Everything widened to 11 bits so bound sums near the bottom cannot wrap.
    assign h_ext = {1'b0, hPos};
    assign v_ext = {1'b0, vPos};
    assign x_ext = {1'b0, laserX};
    assign y_ext = {1'b0, laserY};

    assign exits_screen = (y_ext + STEP11 + HEIGHT11) > BOTTOM11;

    // laserX - W/2 <= hPos is written as laserX <= hPos + W/2, which gives the
    // clamp-at-zero behaviour for free.
    assign on_laser = (state == ST_FLYING)
                   && (x_ext <= h_ext + HALF_W11)
                   && (h_ext <  x_ext + HALF_W11)
                   && (v_ext >= y_ext)
                   && (v_ext <  y_ext + HEIGHT11);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= ST_IDLE;
            laserActive <= 1'b0;
            laserX      <= '0;
            laserY      <= '0;
            color       <= COL_NONE;
`ifdef LASER_COOLDOWN_EN
            cool_cnt    <= '0;
`endif
        end else begin
            color <= on_laser ? COL_LASER : COL_NONE;

            case (state)
                ST_IDLE: begin
                    if (fire_edge) begin
                        state       <= ST_FLYING;
                        laserActive <= 1'b1;
                        laserX      <= gunPosition;
                        laserY      <= LAUNCH_Y;
                    end
                end
                ST_FLYING: begin
                    // A hit wins over a same-cycle frameTick: no final move.
                    if (hit) begin
                        state       <= ST_END;
                        laserActive <= 1'b0;
                    end else if (frameTick) begin
                        if (exits_screen) begin
                            state       <= ST_END;
                            laserActive <= 1'b0;
                        end else begin
                            laserY <= laserY + STEP10;
                        end
                    end
                end
                ST_END: begin
`ifdef LASER_COOLDOWN_EN
                    state    <= ST_COOL;
                    cool_cnt <= COOL_W'(COOLDOWN);
`else
                    state    <= ST_IDLE;
`endif
                end
`ifdef LASER_COOLDOWN_EN
                ST_COOL: begin
                    if (cool_cnt == '0) begin
                        state <= ST_IDLE;
                    end else if (frameTick) begin
                        cool_cnt <= cool_cnt - 1'b1;
                    end
                end
`endif
                default: begin
                    state       <= ST_IDLE;
                    laserActive <= 1'b0;
                end
            endcase
        end
    end

endmodule
